// File: rtl/sp_ram_burst_ctrl.sv
// Burst initiator for a single-port, write-first, async-read RAM.
// Streams write beats into the RAM and read beats out of it.
module sp_ram_burst_ctrl #(
  parameter  int DW    = 8,
  parameter  int WORDS = 256,
  localparam int AW    = $clog2(WORDS),
  localparam int LW    = $clog2(WORDS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_qout
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    FIN
  } state_e;

  state_e        state_q;
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;
  logic [LW-1:0] rem_q;
  logic [LW-1:0] frem_q;
  logic          m_valid_q;
  logic [DW-1:0] m_data_q;
  logic          done_q;

  logic in_wr;
  logic in_rd;
  logic wr_hs;
  logic ld;
  logic m_hs;

  // Handshake decode and wrapping pointer increment
  always_comb begin
    in_wr = (state_q == WR);
    in_rd = (state_q == RD);
    ptr_d = (ptr_q == AW'(WORDS - 1)) ? '0 : ptr_q + 1'b1;
    wr_hs = in_wr && s_valid && (rem_q != '0);
    ld    = in_rd && (frem_q != '0) && (!m_valid_q || m_ready);
    m_hs  = m_valid_q && m_ready;
  end

  assign cmd_ready = rst_n && (state_q == IDLE);
  assign s_ready   = in_wr && (rem_q != '0);
  assign ram_we    = wr_hs;
  assign ram_addr  = (in_wr || in_rd) ? ptr_q : '0;
  assign ram_din   = in_wr ? s_data : '0;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  // Burst FSM: pointer, beat counters, read output register, done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      rem_q     <= '0;
      frem_q    <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            ptr_q  <= cmd_addr;
            rem_q  <= cmd_len;
            frem_q <= cmd_len;
            if (cmd_len == '0) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= cmd_write ? WR : RD;
            end
          end
        end
        WR: begin
          if (wr_hs) begin
            ptr_q <= ptr_d;
            rem_q <= rem_q - 1'b1;
            if (rem_q == LW'(1)) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end
          end
        end
        RD: begin
          if (ld) begin
            m_data_q  <= ram_qout;
            m_valid_q <= 1'b1;
            ptr_q     <= ptr_d;
            frem_q    <= frem_q - 1'b1;
          end else if (m_hs) begin
            m_valid_q <= 1'b0;
          end
          if (m_hs) begin
            rem_q <= rem_q - 1'b1;
            if (rem_q == LW'(1)) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sp_ram_burst_ctrl.sv
// Bench for sp_ram_burst_ctrl: RAM model plus an
// address/data reference computed from burst arithmetic.
module tb_sp_ram_burst_ctrl;

  localparam int DW    = 8;
  localparam int WORDS = 256;
  localparam int AW    = $clog2(WORDS);
  localparam int LW    = $clog2(WORDS + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_qout;

  logic [DW-1:0] mem [WORDS];
  logic [DW-1:0] ref_mem [WORDS];
  bit            known [WORDS];

  int cyc = 0;
  int n_run = 0;
  int n_fail = 0;

  sp_ram_burst_ctrl #(.DW(DW), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .done(done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
    .ram_qout(ram_qout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;
  assign ram_qout = mem[ram_addr];

  initial begin
    #5000000;
    $display("FAIL watchdog: sim time expired, required finish");
    $fatal(1);
  end

  // pat: 0 = always on, 1 = random, 2 = 1,0,0,1,0,0...
  task automatic do_burst(input bit wr, input int addr, input int len,
                          input int pat, input string nm);
    logic [DW-1:0] wd [$];
    int t_acc, nw, nr, first_sr, first_mv, last_hs, done_cyc;
    int k, budget, tog, idx, exp_done;
    bit stall, on;
    logic [DW-1:0] held;
    for (int i = 0; i < len; i++) wd.push_back(DW'($urandom));
    nw = 0; nr = 0; first_sr = -1; first_mv = -1;
    last_hs = -1; done_cyc = -1; stall = 0; held = '0; tog = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr;
    cmd_addr = AW'(addr); cmd_len = LW'(len);
    k = 0;
    while (!cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_run++;
    if (!cmd_ready) begin
      n_fail++;
      $display("FAIL %s cmd_accept: cmd_ready=%0b required 1", nm, cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    t_acc = cyc;
    budget = 8 * len + 40;
    k = 0;
    while (done_cyc < 0 && k < budget) begin
      @(negedge clk);
      k++;
      cmd_valid = 1'b0;
      case (pat)
        0: on = 1'b1;
        1: on = 1'($urandom_range(0, 1));
        default: on = (tog % 3 == 0);
      endcase
      tog++;
      if (wr) begin
        s_valid = on;
        s_data = (nw < len) ? wd[nw] : DW'($urandom);
        m_ready = 1'($urandom_range(0, 1));
      end else begin
        s_valid = 1'($urandom_range(0, 1));
        s_data = DW'($urandom);
        m_ready = on;
      end
      #1;
      if (s_ready && first_sr < 0) first_sr = cyc;
      if (m_valid && first_mv < 0) first_mv = cyc;
      n_run++;
      if (busy !== 1'b1 && !done) begin
        n_fail++;
        $display("FAIL %s busy: got %0b required 1 (cyc %0d)", nm, busy, cyc);
      end
      n_run++;
      if (ram_we !== (wr && s_valid && s_ready) || (!wr && s_ready)) begin
        n_fail++;
        $display("FAIL %s ram_we: got we=%0b s_ready=%0b s_valid=%0b wr=%0b",
                 nm, ram_we, s_ready, s_valid, wr);
      end
      if (wr && s_valid && s_ready) begin
        n_run++;
        if (nw >= len) begin
          n_fail++;
          $display("FAIL %s extra_write: beat %0d of %0d", nm, nw, len);
        end else begin
          idx = (addr + nw) % WORDS;
          if (ram_addr !== AW'(idx) || ram_din !== wd[nw]) begin
            n_fail++;
            $display("FAIL %s write_beat%0d: addr=%0h din=%0h required addr=%0h din=%0h",
                     nm, nw, ram_addr, ram_din, idx, wd[nw]);
          end
          ref_mem[idx] = wd[nw];
          known[idx] = 1'b1;
        end
        nw++;
        last_hs = cyc;
      end
      if (m_valid) begin
        n_run++;
        if (wr) begin
          n_fail++;
          $display("FAIL %s m_valid_in_write: got 1 required 0", nm);
        end
        if (stall) begin
          n_run++;
          if (m_data !== held) begin
            n_fail++;
            $display("FAIL %s stall_hold: m_data=%0h required %0h", nm, m_data, held);
          end
        end
        if (m_ready) begin
          idx = (addr + nr) % WORDS;
          if (nr >= len) begin
            n_fail++;
            $display("FAIL %s extra_read: beat %0d of %0d", nm, nr, len);
          end else if (known[idx] && m_data !== ref_mem[idx]) begin
            n_fail++;
            $display("FAIL %s read_beat%0d: m_data=%0h required %0h (addr %0h)",
                     nm, nr, m_data, ref_mem[idx], idx);
          end
          nr++;
          last_hs = cyc;
        end
      end
      stall = m_valid && !m_ready;
      held = m_data;
      if (done) done_cyc = cyc;
    end
    n_run++;
    if (done_cyc < 0) begin
      n_fail++;
      $display("FAIL %s done_timeout: no done within %0d cycles", nm, budget);
    end
    n_run++;
    if ((wr ? nw : nr) != len) begin
      n_fail++;
      $display("FAIL %s beat_count: got %0d required %0d", nm, wr ? nw : nr, len);
    end
    exp_done = (len == 0) ? t_acc + 1 : last_hs + 1;
    n_run++;
    if (done_cyc != exp_done) begin
      n_fail++;
      $display("FAIL %s done_time: got cyc %0d required %0d", nm, done_cyc, exp_done);
    end
    if (len == 0) begin
      n_run++;
      if (first_sr >= 0 || first_mv >= 0) begin
        n_fail++;
        $display("FAIL %s len0_activity: s_ready at %0d m_valid at %0d required none",
                 nm, first_sr, first_mv);
      end
    end else if (pat == 0) begin
      n_run++;
      if (wr ? (first_sr != t_acc + 1) : (first_mv != t_acc + 2)) begin
        n_fail++;
        $display("FAIL %s first_beat_latency: got %0d required %0d",
                 nm, wr ? first_sr - t_acc : first_mv - t_acc, wr ? 1 : 2);
      end
      n_run++;
      if (done_cyc != t_acc + len + (wr ? 1 : 2)) begin
        n_fail++;
        $display("FAIL %s full_rate_done: got %0d required %0d",
                 nm, done_cyc - t_acc, len + (wr ? 1 : 2));
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b0;
    #1;
    n_run++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_done: done=%0b cmd_ready=%0b busy=%0b required 0,1,0",
               nm, done, cmd_ready, busy);
    end
  endtask

  task automatic test_reset();
    #2;
    rst_n = 1'b0;
    #1;
    n_run++;
    if (cmd_ready !== 1'b0 || m_valid !== 1'b0 || m_data !== '0 ||
        busy !== 1'b0 || done !== 1'b0 || ram_we !== 1'b0 || ram_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_values: rdy=%0b mv=%0b md=%0h busy=%0b done=%0b we=%0b addr=%0h",
               cmd_ready, m_valid, m_data, busy, done, ram_we, ram_addr);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_run++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: cmd_ready=%0b busy=%0b required 1,0", cmd_ready, busy);
    end
  endtask

  task automatic test_write_read();
    do_burst(1'b1, 'h10, 4, 0, "write_basic");
    do_burst(1'b0, 'h10, 4, 0, "read_basic");
  endtask

  task automatic test_read_stall();
    do_burst(1'b0, 'h10, 4, 2, "read_stall");
    do_burst(1'b1, 'h20, 6, 2, "write_gaps");
    do_burst(1'b0, 'h20, 6, 1, "read_random");
  endtask

  task automatic test_wrap();
    do_burst(1'b1, WORDS - 2, 4, 0, "wrap_write");
    do_burst(1'b0, WORDS - 2, 4, 0, "wrap_read");
    do_burst(1'b0, WORDS - 2, 4, 1, "wrap_read_rand");
  endtask

  task automatic test_len_zero();
    do_burst(1'b1, 'h33, 0, 0, "len0_write");
    do_burst(1'b0, 'h33, 0, 0, "len0_read");
  endtask

  task automatic test_reset_mid_burst();
    logic [DW-1:0] d [4];
    do_burst(1'b1, 'h40, 4, 0, "pre_reset_fill");
    for (int i = 0; i < 4; i++) d[i] = DW'($urandom);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1;
    cmd_addr = AW'('h40); cmd_len = LW'(4);
    #1;
    n_run++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_accept: cmd_ready=%0b required 1", cmd_ready);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      s_valid = 1'b1;
      s_data = d[i];
      #1;
      n_run++;
      if (ram_we !== 1'b1 || ram_addr !== AW'('h40 + i)) begin
        n_fail++;
        $display("FAIL rst_mid_beat%0d: we=%0b addr=%0h required 1,%0h",
                 i, ram_we, ram_addr, 'h40 + i);
      end
      ref_mem['h40 + i] = d[i];
      known['h40 + i] = 1'b1;
    end
    @(negedge clk);
    s_valid = 1'b1;
    s_data = d[2];
    #1;
    rst_n = 1'b0;
    #1;
    n_run++;
    if (ram_we !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0 ||
        done !== 1'b0 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_abort: we=%0b busy=%0b rdy=%0b done=%0b s_ready=%0b required 0",
               ram_we, busy, cmd_ready, done, s_ready);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_run++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_no_done: done=%0b required 0", done);
      end
    end
    s_valid = 1'b0;
    rst_n = 1'b1;
    do_burst(1'b0, 'h40, 4, 0, "rst_readback");
  endtask

  task automatic test_random();
    int a, l;
    bit w;
    for (int n = 0; n < 12; n++) begin
      w = 1'($urandom_range(0, 1));
      a = $urandom_range(0, WORDS - 1);
      l = $urandom_range(0, 12);
      do_burst(w, a, l, $urandom_range(0, 2), w ? "rand_write" : "rand_read");
      if (w) do_burst(1'b0, a, l, $urandom_range(0, 2), "rand_readback");
    end
    a = $urandom_range(0, WORDS - 1);
    do_burst(1'b1, a, WORDS + 5, 1, "long_write");
    do_burst(1'b0, a, WORDS + 5, 1, "long_read");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_read_stall();
    test_wrap();
    test_len_zero();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
